// File: rtl/axi4_lite_master_adapter.sv
// Single-outstanding bridge from a local valid/ready request port to an AXI4-Lite master.
// Optional error-response counter enabled by defining AXI4L_MST_ERR_CNT_EN.
//
// state | meaning
// IDLE  | ready for a local request
// WR    | AW and W in flight, each retired independently
// WR_B  | waiting for the write response
// RD_AR | read address in flight
// RD_R  | waiting for read data
// RSP   | holding the local response until rsp_ready
module axi4_lite_master_adapter #(
   parameter int         AXI_ADDR_WIDTH = 12,
   parameter int         AXI_DATA_WIDTH = 32,
   parameter logic [2:0] AXPROT         = 3'b000
) (
   input  logic                        aclk,
   input  logic                        reset,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic                        req_write,
   input  logic [AXI_ADDR_WIDTH-1:0]   req_addr,
   input  logic [AXI_DATA_WIDTH-1:0]   req_wdata,
   input  logic [AXI_DATA_WIDTH/8-1:0] req_wstrb,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
   output logic                        rsp_err,
   output logic [15:0]                 err_count,
   output logic [AXI_ADDR_WIDTH-1:0]   awaddr,
   output logic [2:0]                  awprot,
   output logic                        awvalid,
   input  logic                        awready,
   output logic [AXI_DATA_WIDTH-1:0]   wdata,
   output logic [AXI_DATA_WIDTH/8-1:0] wstrb,
   output logic                        wvalid,
   input  logic                        wready,
   input  logic [1:0]                  bresp,
   input  logic                        bvalid,
   output logic                        bready,
   output logic [AXI_ADDR_WIDTH-1:0]   araddr,
   output logic [2:0]                  arprot,
   output logic                        arvalid,
   input  logic                        arready,
   input  logic [AXI_DATA_WIDTH-1:0]   rdata,
   input  logic [1:0]                  rresp,
   input  logic                        rvalid,
   output logic                        rready
);

   typedef enum logic [2:0] {IDLE, WR, WR_B, RD_AR, RD_R, RSP} state_t;

   state_t                      state, state_nxt;
   logic                        aw_done, w_done, aw_done_nxt, w_done_nxt;
   logic [AXI_ADDR_WIDTH-1:0]   addr_q;
   logic                        req_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs;
   logic                        unused_resp_lsb;

   assign req_hs = req_valid & req_ready;
   assign aw_hs  = awvalid & awready;
   assign w_hs   = wvalid & wready;
   assign b_hs   = bvalid & bready;
   assign ar_hs  = arvalid & arready;
   assign r_hs   = rvalid & rready;
   assign rsp_hs = rsp_valid & rsp_ready;

   assign awaddr = addr_q;
   assign araddr = addr_q;
   assign awprot = AXPROT;
   assign arprot = AXPROT;

   // Only bit 1 of xRESP distinguishes error responses; EXOKAY is treated as OKAY.
   assign unused_resp_lsb = bresp[0] ^ rresp[0];

   always_comb begin
      state_nxt   = state;
      aw_done_nxt = aw_done;
      w_done_nxt  = w_done;
      case (state)
         IDLE: begin
            if (req_hs) begin
               state_nxt   = req_write ? WR : RD_AR;
               aw_done_nxt = 1'b0;
               w_done_nxt  = 1'b0;
            end
         end
         WR: begin
            aw_done_nxt = aw_done | aw_hs;
            w_done_nxt  = w_done | w_hs;
            if (aw_done_nxt && w_done_nxt) state_nxt = WR_B;
         end
         WR_B:    if (b_hs)   state_nxt = RSP;
         RD_AR:   if (ar_hs)  state_nxt = RD_R;
         RD_R:    if (r_hs)   state_nxt = RSP;
         RSP:     if (rsp_hs) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake outputs are registered copies of the next-state decode.
   always_ff @(posedge aclk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         req_ready <= 1'b0;
         awvalid   <= 1'b0;
         wvalid    <= 1'b0;
         bready    <= 1'b0;
         arvalid   <= 1'b0;
         rready    <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
         addr_q    <= '0;
         wdata     <= '0;
         wstrb     <= '0;
      end else begin
         state     <= state_nxt;
         aw_done   <= aw_done_nxt;
         w_done    <= w_done_nxt;
         req_ready <= (state_nxt == IDLE);
         awvalid   <= (state_nxt == WR) && !aw_done_nxt;
         wvalid    <= (state_nxt == WR) && !w_done_nxt;
         bready    <= (state_nxt == WR_B);
         arvalid   <= (state_nxt == RD_AR);
         rready    <= (state_nxt == RD_R);
         rsp_valid <= (state_nxt == RSP);
         if (req_hs) begin
            addr_q <= req_addr;
            wdata  <= req_wdata;
            wstrb  <= req_wstrb;
         end
         if (b_hs) begin
            rsp_rdata <= '0;
            rsp_err   <= bresp[1];
         end
         if (r_hs) begin
            rsp_rdata <= rdata;
            rsp_err   <= rresp[1];
         end
      end
   end

`ifdef AXI4L_MST_ERR_CNT_EN
   logic [15:0] err_cnt_q;

   always_ff @(posedge aclk or posedge reset) begin
      if (reset)
         err_cnt_q <= 16'h0000;
      else if (rsp_hs && rsp_err && (err_cnt_q != 16'hFFFF))
         err_cnt_q <= err_cnt_q + 16'd1;
   end

   assign err_count = err_cnt_q;
`else
   assign err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_axi4_lite_master_adapter.sv
// Bench for axi4_lite_master_adapter: directed vector table, randomized transactions against
// a transaction-level model, and a reset-during-write-response sequence.
module tb_axi4_lite_master_adapter;
   localparam int AW = 12;
   localparam int DW = 32;
   localparam int SW = DW / 8;
   localparam int BUDGET = 60;

   logic          aclk = 1'b0;
   logic          reset;
   logic          req_valid, req_ready, req_write;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic [SW-1:0] req_wstrb;
   logic          rsp_valid, rsp_ready, rsp_err;
   logic [DW-1:0] rsp_rdata;
   logic [15:0]   err_count;
   logic [AW-1:0] awaddr, araddr;
   logic [2:0]    awprot, arprot;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rvalid, rready;
   logic [DW-1:0] wdata, rdata;
   logic [SW-1:0] wstrb;
   logic [1:0]    bresp, rresp;

   axi4_lite_master_adapter #(
      .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXPROT(3'b000)
   ) dut (
      .aclk(aclk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .err_count(err_count),
      .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
   );

   always #5 aclk = ~aclk;

   int unsigned cyc = 0;
   always @(posedge aclk) cyc++;

   // Passive monitors: counted on the falling edge, away from the DUT's update edge.
   int unsigned aw_cyc = 0, w_cyc = 0, b_hs_n = 0, rsp_hs_n = 0, rsp_vcyc = 0, unstable_n = 0;
   logic          prev_awv = 1'b0, prev_wv = 1'b0;
   logic [AW-1:0] prev_awaddr = '0;
   logic [DW-1:0] prev_wdata = '0;
   always @(negedge aclk) begin
      if (awvalid) aw_cyc++;
      if (wvalid) w_cyc++;
      if (bvalid && bready) b_hs_n++;
      if (rsp_valid) rsp_vcyc++;
      if (rsp_valid && rsp_ready) rsp_hs_n++;
      if (awvalid && prev_awv && awaddr !== prev_awaddr) unstable_n++;
      if (wvalid && prev_wv && wdata !== prev_wdata) unstable_n++;
      prev_awv    = awvalid;
      prev_wv     = wvalid;
      prev_awaddr = awaddr;
      prev_wdata  = wdata;
   end

   int n_pass = 0, n_total = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   typedef struct {
      bit          write;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          aw_dly, w_dly, b_dly, ar_dly, r_dly, rsp_dly;
      logic [1:0]  resp;
      logic [31:0] rdata;
      logic [31:0] exp_rdata;
      bit          exp_err;
      int          exp_lat;
   } vec_t;

   // Transaction-level expectation: data/err by rule, latency from channel delays.
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      int   mx;
      r.exp_rdata = v.write ? 32'h0 : v.rdata;
      r.exp_err   = v.resp[1];
      mx          = (v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly;
      r.exp_lat   = v.write ? (3 + mx + v.b_dly) : (3 + v.ar_dly + v.r_dly);
      return r;
   endfunction

   int unsigned   exp_errcnt = 0;
   int unsigned   a_cyc, to_n;
   bit            aw_done, w_done;
   logic [AW-1:0] got_awaddr, got_araddr;
   logic [DW-1:0] got_wdata, got_rdata;
   logic [SW-1:0] got_wstrb;
   logic          got_err, rr_busy, rr_after, rsp_moved;
   int            got_lat;

   task automatic wait_cycle();
      @(posedge aclk);
      #1;
   endtask

   task automatic aw_chan(input int dly);
      int n = 0;
      while (!awvalid && n < BUDGET) begin wait_cycle(); n++; end
      if (n >= BUDGET) to_n++;
      repeat (dly) wait_cycle();
      awready    = 1'b1;
      got_awaddr = awaddr;
      @(posedge aclk);
      aw_done = 1'b1;
      #1 awready = 1'b0;
   endtask

   task automatic w_chan(input int dly);
      int n = 0;
      while (!wvalid && n < BUDGET) begin wait_cycle(); n++; end
      if (n >= BUDGET) to_n++;
      repeat (dly) wait_cycle();
      wready    = 1'b1;
      got_wdata = wdata;
      got_wstrb = wstrb;
      @(posedge aclk);
      w_done = 1'b1;
      #1 wready = 1'b0;
   endtask

   task automatic b_chan(input int dly, input logic [1:0] resp);
      int n = 0;
      while (!(aw_done && w_done) && n < BUDGET) begin wait_cycle(); n++; end
      repeat (dly) wait_cycle();
      bvalid = 1'b1;
      bresp  = resp;
      n = 0;
      while (!bready && n < BUDGET) begin wait_cycle(); n++; end
      if (n >= BUDGET) to_n++;
      wait_cycle();
      bvalid = 1'b0;
      bresp  = 2'b00;
   endtask

   task automatic ar_r_chan(input int ar_dly, input int r_dly, input logic [1:0] resp,
                            input logic [31:0] data);
      int n = 0;
      while (!arvalid && n < BUDGET) begin wait_cycle(); n++; end
      if (n >= BUDGET) to_n++;
      repeat (ar_dly) wait_cycle();
      arready    = 1'b1;
      got_araddr = araddr;
      wait_cycle();
      arready = 1'b0;
      repeat (r_dly) wait_cycle();
      rvalid = 1'b1;
      rdata  = data;
      rresp  = resp;
      n = 0;
      while (!rready && n < BUDGET) begin wait_cycle(); n++; end
      if (n >= BUDGET) to_n++;
      wait_cycle();
      rvalid = 1'b0;
      rdata  = 32'h0;
      rresp  = 2'b00;
   endtask

   task automatic rsp_chan(input int dly);
      int n = 0;
      while (!rsp_valid && n < BUDGET) begin wait_cycle(); n++; end
      if (n >= BUDGET) to_n++;
      got_lat   = int'(cyc - a_cyc) + 1;
      got_rdata = rsp_rdata;
      got_err   = rsp_err;
      rr_busy   = req_ready;
      rsp_moved = 1'b0;
      repeat (dly) begin
         wait_cycle();
         if (rsp_valid !== 1'b1 || rsp_rdata !== got_rdata || rsp_err !== got_err) rsp_moved = 1'b1;
      end
      rsp_ready = 1'b1;
      wait_cycle();
      rsp_ready = 1'b0;
      rr_after  = req_ready;
   endtask

   task automatic do_txn(input vec_t v, input string tag);
      int n = 0;
      int unsigned s_aw, s_w, s_b, s_hs, s_vc, s_un;
      logic [15:0] exp_ec;
      to_n = 0;
      while (!req_ready && n < BUDGET) begin wait_cycle(); n++; end
      if (n >= BUDGET) to_n++;
      req_valid = 1'b1;
      req_write = v.write;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      req_wstrb = v.wstrb;
      s_aw = aw_cyc; s_w = w_cyc; s_b = b_hs_n; s_hs = rsp_hs_n; s_vc = rsp_vcyc; s_un = unstable_n;
      aw_done = 1'b0;
      w_done  = 1'b0;
      wait_cycle();
      a_cyc     = cyc;
      req_valid = 1'b0;
      req_addr  = ~v.addr;
      req_wdata = ~v.wdata;
      req_wstrb = ~v.wstrb;
      fork
         begin if (v.write) aw_chan(v.aw_dly); end
         begin if (v.write) w_chan(v.w_dly); end
         begin if (v.write) b_chan(v.b_dly, v.resp); end
         begin if (!v.write) ar_r_chan(v.ar_dly, v.r_dly, v.resp, v.rdata); end
         rsp_chan(v.rsp_dly);
      join
      chk({tag, " timeout"}, 64'(to_n), 64'd0);
      chk({tag, " latency"}, 64'(got_lat), 64'(v.exp_lat));
      chk({tag, " rsp_rdata"}, 64'(got_rdata), 64'(v.exp_rdata));
      chk({tag, " rsp_err"}, 64'(got_err), 64'(v.exp_err));
      chk({tag, " rsp_stable"}, 64'(rsp_moved), 64'd0);
      chk({tag, " rsp_valid_cycles"}, 64'(rsp_vcyc - s_vc), 64'(v.rsp_dly + 1));
      chk({tag, " rsp_handshakes"}, 64'(rsp_hs_n - s_hs), 64'd1);
      chk({tag, " req_ready_busy"}, 64'(rr_busy), 64'd0);
      chk({tag, " req_ready_after"}, 64'(rr_after), 64'd1);
      if (v.write) begin
         chk({tag, " awaddr"}, 64'(got_awaddr), 64'(v.addr));
         chk({tag, " wdata"}, 64'(got_wdata), 64'(v.wdata));
         chk({tag, " wstrb"}, 64'(got_wstrb), 64'(v.wstrb));
         chk({tag, " awvalid_cycles"}, 64'(aw_cyc - s_aw), 64'(v.aw_dly + 1));
         chk({tag, " wvalid_cycles"}, 64'(w_cyc - s_w), 64'(v.w_dly + 1));
         chk({tag, " b_handshakes"}, 64'(b_hs_n - s_b), 64'd1);
         chk({tag, " payload_stable"}, 64'(unstable_n - s_un), 64'd0);
      end else begin
         chk({tag, " araddr"}, 64'(got_araddr), 64'(v.addr));
      end
      if (v.exp_err && exp_errcnt < 32'hFFFF) exp_errcnt++;
`ifdef AXI4L_MST_ERR_CNT_EN
      exp_ec = 16'(exp_errcnt);
`else
      exp_ec = 16'h0000;
`endif
      chk({tag, " err_count"}, 64'(err_count), 64'(exp_ec));
   endtask

   vec_t tbl[8];
   vec_t rv;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
      rsp_ready = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
      aw_done = 1'b0; w_done = 1'b0;

      //          wr  addr     wdata         strb  aw w  b  ar r  rsp resp   rdata         exp_rdata     err lat
      tbl[0] = '{1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0,        32'h0,        0, 3};
      tbl[1] = '{1'b1, 12'h044, 32'hCAFEF00D, 4'h3, 3, 0, 0, 0, 0, 0, 2'b00, 32'h0,        32'h0,        0, 6};
      tbl[2] = '{1'b0, 12'h020, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2, 2'b10, 32'h12345678, 32'h12345678, 1, 3};
      tbl[3] = '{1'b1, 12'h7FF, 32'h00000001, 4'h0, 0, 2, 1, 0, 0, 0, 2'b01, 32'h0,        32'h0,        0, 6};
      tbl[4] = '{1'b1, 12'hFFF, 32'hA5A5A5A5, 4'hF, 2, 2, 0, 0, 0, 1, 2'b11, 32'h0,        32'h0,        1, 5};
      tbl[5] = '{1'b0, 12'h003, 32'h0,        4'h0, 0, 0, 0, 1, 2, 0, 2'b01, 32'h0BADF00D, 32'h0BADF00D, 0, 6};
      tbl[6] = '{1'b0, 12'hFFE, 32'h0,        4'h0, 0, 0, 0, 0, 0, 1, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 3};
      tbl[7] = '{1'b1, 12'h001, 32'h11223344, 4'h5, 0, 3, 2, 0, 0, 0, 2'b10, 32'h0,        32'h0,        1, 8};

      repeat (3) wait_cycle();
      chk("reset handshake outputs",
          64'({req_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_err}), 64'd0);
      chk("reset rsp_rdata", 64'(rsp_rdata), 64'd0);
      chk("reset err_count", 64'(err_count), 64'd0);
      reset = 1'b0;
      wait_cycle();
      chk("req_ready after reset", 64'(req_ready), 64'd1);

      for (int i = 0; i < 8; i++) do_txn(tbl[i], $sformatf("vec%0d", i));

      for (int i = 0; i < 40; i++) begin
         rv.write   = 1'($urandom_range(0, 1));
         rv.addr    = 12'($urandom);
         rv.wdata   = $urandom;
         rv.wstrb   = 4'($urandom);
         rv.aw_dly  = $urandom_range(0, 3);
         rv.w_dly   = $urandom_range(0, 3);
         rv.b_dly   = $urandom_range(0, 3);
         rv.ar_dly  = $urandom_range(0, 3);
         rv.r_dly   = $urandom_range(0, 3);
         rv.rsp_dly = $urandom_range(0, 2);
         rv.resp    = 2'($urandom);
         rv.rdata   = $urandom;
         do_txn(model(rv), $sformatf("rnd%0d", i));
      end

      // Reset while the write response is outstanding: transaction dropped, no response.
      begin
         int unsigned s_vc;
         int n = 0;
         while (!req_ready && n < BUDGET) begin wait_cycle(); n++; end
         req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h0AB;
         req_wdata = 32'h55AA55AA; req_wstrb = 4'hF;
         awready = 1'b1; wready = 1'b1;
         wait_cycle();
         req_valid = 1'b0;
         wait_cycle();
         awready = 1'b0; wready = 1'b0;
         chk("rst_wr_b bready before reset", 64'(bready), 64'd1);
         wait_cycle();
         reset = 1'b1;
         #1;
         chk("rst_wr_b handshake outputs",
             64'({req_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_err}), 64'd0);
         chk("rst_wr_b rsp_rdata", 64'(rsp_rdata), 64'd0);
         chk("rst_wr_b err_count", 64'(err_count), 64'd0);
         chk("rst_wr_b awaddr", 64'(awaddr), 64'd0);
         exp_errcnt = 0;
         s_vc = rsp_vcyc;
         bvalid = 1'b1; bresp = 2'b10;
         repeat (2) wait_cycle();
         bvalid = 1'b0; bresp = 2'b00;
         reset = 1'b0;
         wait_cycle();
         chk("rst_wr_b req_ready after release", 64'(req_ready), 64'd1);
         repeat (3) wait_cycle();
         chk("rst_wr_b no response", 64'(rsp_vcyc - s_vc), 64'd0);
         chk("rst_wr_b idle bready", 64'({bready, req_ready}), 64'b01);
      end

      do_txn(tbl[2], "post_reset_read");
      do_txn(tbl[0], "post_reset_write");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/axi4_lite_master_adapter.md
AXI4_LITE_MASTER_ADAPTER -- requirements
Module: axi4_lite_master_adapter
Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 12, AXI address width.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 32, AXI data width (multiple of 8).
REQ-003 SHALL have parameter AXPROT, default 3'b000, value driven on awprot/arprot.
REQ-004 aclk  input  1  single clock, all logic rising-edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  1  local request valid.
REQ-007 req_ready  output  1  local request accepted when high with req_valid.
REQ-008 req_write  input  1  1=write, 0=read.
REQ-009 req_addr  input  AXI_ADDR_WIDTH  request address.
REQ-010 req_wdata  input  AXI_DATA_WIDTH  write data.
REQ-011 req_wstrb  input  AXI_DATA_WIDTH/8  write byte strobes.
REQ-012 rsp_valid  output  1  response valid.
REQ-013 rsp_ready  input  1  response accepted.
REQ-014 rsp_rdata  output  AXI_DATA_WIDTH  read data; 0 for writes.
REQ-015 rsp_err  output  1  1 when xRESP[1]=1 (SLVERR/DECERR).
REQ-016 err_count  output  16  error-response count (see Configuration).
REQ-017 awaddr  output  AXI_ADDR_WIDTH  write address.
REQ-018 awprot  output  3  constant AXPROT.
REQ-019 awvalid  output  1  write address valid.
REQ-020 awready  input  1  write address ready.
REQ-021 wdata  output  AXI_DATA_WIDTH  write data.
REQ-022 wstrb  output  AXI_DATA_WIDTH/8  write strobes.
REQ-023 wvalid  output  1  write data valid.
REQ-024 wready  input  1  write data ready.
REQ-025 bresp  input  2  write response.
REQ-026 bvalid  input  1  write response valid.
REQ-027 bready  output  1  write response ready.
REQ-028 araddr  output  AXI_ADDR_WIDTH  read address.
REQ-029 arprot  output  3  constant AXPROT.
REQ-030 arvalid  output  1  read address valid.
REQ-031 arready  input  1  read address ready.
REQ-032 rdata  input  AXI_DATA_WIDTH  read data.
REQ-033 rresp  input  2  read response.
REQ-034 rvalid  input  1  read data valid.
REQ-035 rready  output  1  read data ready.
Function
REQ-036 FSM states IDLE, WR, WR_B, RD_AR, RD_R, RSP; req_ready=1 only in IDLE; on req_valid&req_ready capture write/addr/wdata/wstrb into registers and go to WR (req_write=1) or RD_AR; one transaction outstanding.
REQ-037 WR: awvalid and wvalid SHALL both rise the cycle after acceptance, each held with stable payload until its own handshake; aw/w completions tracked independently (either order or same cycle); both complete -> WR_B with bready=1.
REQ-038 WR_B: on bvalid&bready -> RSP with rsp_err=bresp[1], rsp_rdata=0; RD_AR: arvalid held until arready -> RD_R with rready=1; on rvalid&rready -> RSP with rsp_rdata=rdata, rsp_err=rresp[1].
REQ-039 RSP: rsp_valid=1, payload stable until rsp_ready, then IDLE; next request accepted no earlier than the cycle after the response handshake.
REQ-040 Zero-wait slave (ready high, response one cycle after handshake): request accepted at edge 0 -> rsp_valid high in cycle 3.
REQ-041 All outputs driven from registers; addresses passed unmodified (no alignment); req_wstrb=0 still issues a write; bresp[0]/rresp[0] ignored.
Reset
REQ-042 While reset=1: FSM IDLE, all AXI valids/readies, req_ready, rsp_valid, rsp_err, rsp_rdata, err_count = 0; assertion mid-transaction abandons it with no response; req_ready=1 the first cycle after deassertion.
Configuration
REQ-043 Macro AXI4L_MST_ERR_CNT_EN defined: err_count +1 per response handshake with rsp_err=1, saturating at 16'hFFFF; undefined: no counter, err_count constant 0.
Verification
REQ-044 Write addr 12'h010, wdata 32'hDEADBEEF, wstrb 4'hF, zero-wait slave, bresp 2'b00 -> awaddr 12'h010/wdata DEADBEEF seen; rsp_valid cycle 3, rsp_err 0.
REQ-045 Write with awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles, single B accepted, one response.
REQ-046 Read addr 12'h020, rdata 32'h12345678, rresp 2'b10, rsp_ready low 2 cycles -> rsp_rdata 12345678, rsp_err 1 held stable 3 cycles; with macro err_count=1.
REQ-047 Reset asserted in WR_B before bvalid -> all outputs 0 immediately; req_ready=1 after deassertion; no rsp_valid.
